// File: rtl/alu_cmd_sequencer_if.sv
// Handshake and ALU-side signal bundle for alu_cmd_sequencer.
// The slave modport is the sequencer's view; master is the command source / ALU environment.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH  = 16,
    parameter int REG_AW = 2
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [REG_AW-1:0] cmd_dst;
    logic [REG_AW-1:0] cmd_src_a;
    logic [REG_AW-1:0] cmd_src_b;
    logic              cmd_imm_en;
    logic [WIDTH-1:0]  cmd_imm;
    logic              cmd_wb;

    logic              ld_en;
    logic [REG_AW-1:0] ld_addr;
    logic [WIDTH-1:0]  ld_data;

    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [2:0]        alu_sel;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_carry;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_data;
    logic              rsp_carry;
    logic              rsp_zero;

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b,
               cmd_imm_en, cmd_imm, cmd_wb,
               ld_en, ld_addr, ld_data,
               alu_result, alu_carry, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel,
               rsp_valid, rsp_data, rsp_carry, rsp_zero
    );

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b,
               cmd_imm_en, cmd_imm, cmd_wb,
               ld_en, ld_addr, ld_data,
               alu_result, alu_carry, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel,
               rsp_valid, rsp_data, rsp_carry, rsp_zero
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the combinational ALU: reads operands from a small register file,
// drives the ALU for one cycle, captures the result, writes it back and returns a response.
module alu_cmd_sequencer #(
    parameter int WIDTH  = 16,
    parameter int REG_AW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_sequencer_if.slave   bus
);
    localparam int NREG = 1 << REG_AW;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [WIDTH-1:0]  rf_q [NREG];
    logic [WIDTH-1:0]  rf_d [NREG];
    logic [WIDTH-1:0]  alu_a_q,     alu_a_d;
    logic [WIDTH-1:0]  alu_b_q,     alu_b_d;
    logic [2:0]        alu_sel_q,   alu_sel_d;
    logic [REG_AW-1:0] dst_q,       dst_d;
    logic              wb_q,        wb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_data_q,  rsp_data_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic              rsp_zero_q,  rsp_zero_d;

    always_comb begin
        state_d     = state_q;
        rf_d        = rf_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        dst_d       = dst_q;
        wb_d        = wb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;

        // Direct load goes first so a same-edge writeback to that address overrides it.
        if (bus.ld_en) begin
            rf_d[bus.ld_addr] = bus.ld_data;
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    alu_a_d   = rf_q[bus.cmd_src_a];
                    alu_b_d   = bus.cmd_imm_en ? bus.cmd_imm : rf_q[bus.cmd_src_b];
                    alu_sel_d = bus.cmd_op;
                    dst_d     = bus.cmd_dst;
                    wb_d      = bus.cmd_wb;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = bus.alu_result;
                rsp_carry_d = bus.alu_carry;
                rsp_zero_d  = (bus.alu_result == '0);
                rsp_valid_d = 1'b1;
                if (wb_q) begin
                    rf_d[dst_q] = bus.alu_result;
                end
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            dst_q       <= '0;
            wb_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            dst_q       <= dst_d;
            wb_q        <= wb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.rsp_zero  = rsp_zero_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: a table of single commands plus hand-written
// sequences for backpressure, dependent commands, load/writeback collisions and mid-flight reset.
module tb_alu_cmd_sequencer;
    logic clk;
    logic rst;
    int   nChecks;
    int   nFails;

    alu_cmd_sequencer_if #(.WIDTH(16), .REG_AW(2)) intf ();

    alu_cmd_sequencer #(.WIDTH(16), .REG_AW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the ALU: 000 add, 001 sub (carry = borrow), 101 increment A, 111 xor.
    always_comb begin
        logic [16:0] sum;
        sum            = 17'({1'b0, intf.alu_a} + {1'b0, intf.alu_b});
        intf.alu_carry = 1'b0;
        case (intf.alu_sel)
            3'b000: begin intf.alu_result = sum[15:0]; intf.alu_carry = sum[16]; end
            3'b001: begin intf.alu_result = intf.alu_a - intf.alu_b;
                          intf.alu_carry  = (intf.alu_a < intf.alu_b); end
            3'b010: intf.alu_result = intf.alu_a & intf.alu_b;
            3'b011: intf.alu_result = intf.alu_a | intf.alu_b;
            3'b100: intf.alu_result = ~intf.alu_a;
            3'b101: intf.alu_result = intf.alu_a + 16'd1;
            3'b110: intf.alu_result = intf.alu_a << 1;
            default: intf.alu_result = intf.alu_a ^ intf.alu_b;
        endcase
    end

    typedef struct {
        logic [15:0] r0;
        logic [15:0] r1;
        logic [2:0]  op;
        logic [1:0]  dst;
        logic        immEn;
        logic [15:0] imm;
        logic        wb;
        logic [15:0] expA;
        logic [15:0] expB;
        logic [15:0] expData;
        logic        expCarry;
        logic        expZero;
        logic [15:0] expDst;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic loadReg(input logic [1:0] addr, input logic [15:0] data);
        intf.ld_en   = 1'b1;
        intf.ld_addr = addr;
        intf.ld_data = data;
        tick();
        intf.ld_en   = 1'b0;
    endtask

    task automatic setCmd(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] a,
                          input logic [1:0] b, input logic immEn, input logic [15:0] imm,
                          input logic wb);
        intf.cmd_valid  = 1'b1;
        intf.cmd_op     = op;
        intf.cmd_dst    = dst;
        intf.cmd_src_a  = a;
        intf.cmd_src_b  = b;
        intf.cmd_imm_en = immEn;
        intf.cmd_imm    = imm;
        intf.cmd_wb     = wb;
    endtask

    task automatic handshake();
        intf.rsp_ready = 1'b1;
        tick();
        intf.rsp_ready = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        loadReg(2'd0, v.r0);
        loadReg(2'd1, v.r1);
        setCmd(v.op, v.dst, 2'd0, 2'd1, v.immEn, v.imm, v.wb);
        tick();
        intf.cmd_valid = 1'b0;
        checkOutput({tag, ".cmd_ready_exec"}, 32'(intf.cmd_ready), 32'd0);
        checkOutput({tag, ".alu_a"},   32'(intf.alu_a),   32'(v.expA));
        checkOutput({tag, ".alu_b"},   32'(intf.alu_b),   32'(v.expB));
        checkOutput({tag, ".alu_sel"}, 32'(intf.alu_sel), 32'(v.op));
        tick();
        checkOutput({tag, ".rsp_valid"}, 32'(intf.rsp_valid), 32'd1);
        checkOutput({tag, ".rsp_data"},  32'(intf.rsp_data),  32'(v.expData));
        checkOutput({tag, ".rsp_carry"}, 32'(intf.rsp_carry), 32'(v.expCarry));
        checkOutput({tag, ".rsp_zero"},  32'(intf.rsp_zero),  32'(v.expZero));
        handshake();
        checkOutput({tag, ".rsp_valid_done"}, 32'(intf.rsp_valid), 32'd0);
        checkOutput({tag, ".cmd_ready_idle"}, 32'(intf.cmd_ready), 32'd1);
        checkOutput({tag, ".rf_dst"}, 32'(dut.rf_q[v.dst]), 32'(v.expDst));
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        //          r0       r1       op    dst  imm  immv     wb   expA     expB     data     c     z     dst
        vecs[0] = '{16'hFFFF, 16'h0001, 3'b000, 2'd2, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h0000};
        vecs[1] = '{16'h0003, 16'h0005, 3'b001, 2'd3, 1'b0, 16'h0000, 1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 16'hFFFE};
        vecs[2] = '{16'h00FF, 16'h0005, 3'b111, 2'd3, 1'b1, 16'h0F0F, 1'b0, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 1'b0, 16'hFFFE};
        vecs[3] = '{16'h1234, 16'h0001, 3'b000, 2'd2, 1'b0, 16'h0000, 1'b1, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0, 16'h1235};
        vecs[4] = '{16'h0000, 16'h1111, 3'b001, 2'd1, 1'b1, 16'h0001, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF};
        vecs[5] = '{16'h0005, 16'h0005, 3'b001, 2'd0, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 16'h0000};

        rst = 1'b1;
        intf.cmd_valid = 1'b0; intf.cmd_op = '0; intf.cmd_dst = '0; intf.cmd_src_a = '0;
        intf.cmd_src_b = '0; intf.cmd_imm_en = 1'b0; intf.cmd_imm = '0; intf.cmd_wb = 1'b0;
        intf.ld_en = 1'b0; intf.ld_addr = '0; intf.ld_data = '0; intf.rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        checkOutput("reset.cmd_ready", 32'(intf.cmd_ready), 32'd1);
        checkOutput("reset.rsp_valid", 32'(intf.rsp_valid), 32'd0);
        checkOutput("reset.rsp_data",  32'(intf.rsp_data),  32'd0);
        checkOutput("reset.alu_a",     32'(intf.alu_a),     32'd0);
        checkOutput("reset.alu_sel",   32'(intf.alu_sel),   32'd0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Backpressure: response held while a second command waits on cmd_valid.
        loadReg(2'd0, 16'h0002);
        loadReg(2'd1, 16'h0003);
        setCmd(3'b000, 2'd1, 2'd0, 2'd1, 1'b0, 16'h0000, 1'b0);
        tick();
        setCmd(3'b101, 2'd3, 2'd0, 2'd1, 1'b0, 16'h0000, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp.rsp_valid", 32'(intf.rsp_valid), 32'd1);
            checkOutput("bp.rsp_data",  32'(intf.rsp_data),  32'h0005);
            checkOutput("bp.rsp_carry", 32'(intf.rsp_carry), 32'd0);
            checkOutput("bp.cmd_ready", 32'(intf.cmd_ready), 32'd0);
            tick();
        end
        handshake();
        checkOutput("bp.cmd_ready_after", 32'(intf.cmd_ready), 32'd1);
        checkOutput("bp.rsp_valid_after", 32'(intf.rsp_valid), 32'd0);
        tick();
        intf.cmd_valid = 1'b0;
        checkOutput("bp.cmd2_alu_a",   32'(intf.alu_a),   32'h0002);
        checkOutput("bp.cmd2_alu_sel", 32'(intf.alu_sel), 32'h5);
        tick();
        checkOutput("bp.cmd2_rsp_data", 32'(intf.rsp_data), 32'h0003);
        handshake();
        checkOutput("bp.rf3", 32'(dut.rf_q[3]), 32'h0003);

        // Dependent commands; ld colliding with writeback; ld on accept edge not seen.
        loadReg(2'd0, 16'h1234);
        loadReg(2'd1, 16'h0001);
        setCmd(3'b000, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000, 1'b1);
        tick();
        intf.cmd_valid = 1'b0;
        intf.ld_en = 1'b1; intf.ld_addr = 2'd2; intf.ld_data = 16'hAAAA;
        tick();
        intf.ld_en = 1'b0;
        checkOutput("dep.rsp_data1", 32'(intf.rsp_data), 32'h1235);
        checkOutput("dep.wb_wins",   32'(dut.rf_q[2]),   32'h1235);
        handshake();
        setCmd(3'b101, 2'd3, 2'd2, 2'd0, 1'b0, 16'h0000, 1'b1);
        intf.ld_en = 1'b1; intf.ld_addr = 2'd2; intf.ld_data = 16'h0BAD;
        tick();
        intf.cmd_valid = 1'b0;
        intf.ld_en = 1'b0;
        checkOutput("dep.alu_a_old", 32'(intf.alu_a), 32'h1235);
        tick();
        checkOutput("dep.rsp_data2", 32'(intf.rsp_data), 32'h1236);
        handshake();
        checkOutput("dep.rf2_ld", 32'(dut.rf_q[2]), 32'h0BAD);
        checkOutput("dep.rf3_wb", 32'(dut.rf_q[3]), 32'h1236);
        setCmd(3'b101, 2'd3, 2'd2, 2'd0, 1'b0, 16'h0000, 1'b1);
        tick();
        intf.cmd_valid = 1'b0;
        checkOutput("dep.alu_a_new", 32'(intf.alu_a), 32'h0BAD);
        tick();
        checkOutput("dep.rsp_data3", 32'(intf.rsp_data), 32'h0BAE);
        handshake();

        // Reset asserted while the command is in EXEC.
        loadReg(2'd1, 16'h0007);
        intf.rsp_ready = 1'b1;
        setCmd(3'b000, 2'd3, 2'd1, 2'd1, 1'b0, 16'h0000, 1'b1);
        tick();
        intf.cmd_valid = 1'b0;
        checkOutput("rst.pre_alu_a", 32'(intf.alu_a), 32'h0007);
        rst = 1'b1;
        #1;
        checkOutput("rst.alu_a",     32'(intf.alu_a),     32'd0);
        checkOutput("rst.alu_b",     32'(intf.alu_b),     32'd0);
        checkOutput("rst.rsp_valid", 32'(intf.rsp_valid), 32'd0);
        checkOutput("rst.rsp_data",  32'(intf.rsp_data),  32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rst.rf%0d", i), 32'(dut.rf_q[i]), 32'd0);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rst.after_rsp_valid", 32'(intf.rsp_valid), 32'd0);
            checkOutput("rst.after_cmd_ready", 32'(intf.cmd_ready), 32'd1);
            tick();
        end
        checkOutput("rst.after_rf3", 32'(dut.rf_q[3]), 32'd0);
        intf.rsp_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Initiator-side controller for the 16-bit combinational ALU. Accepts register-level commands over a valid/ready handshake, reads operands from a small internal register file, drives the ALU's operand and select inputs, then captures the ALU result and carry. It writes the result back to the register file and returns result, carry and zero flag over a valid/ready response channel. Sits between the command source (test sequencer or future decode stage) and the existing ALU instance.

Parameters:
WIDTH, 16, datapath width; must match the ALU operand width.
REG_AW, 2, register file address width; the file holds 2**REG_AW entries (default 4).

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_op  input  3  ALU select code, passed unchanged to alu_sel
cmd_dst  input  REG_AW  destination register
cmd_src_a  input  REG_AW  operand A register
cmd_src_b  input  REG_AW  operand B register, used when cmd_imm_en=0
cmd_imm_en  input  1  1: operand B is taken from cmd_imm
cmd_imm  input  WIDTH  immediate operand B
cmd_wb  input  1  1: write the result to cmd_dst
ld_en  input  1  direct register load strobe
ld_addr  input  REG_AW  load address
ld_data  input  WIDTH  load data
alu_a  output  WIDTH  to ALU operand a
alu_b  output  WIDTH  to ALU operand b
alu_sel  output  3  to ALU select input
alu_result  input  WIDTH  from ALU result output
alu_carry  input  1  from bit 0 of the ALU carry output
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts the response
rsp_data  output  WIDTH  captured result
rsp_carry  output  1  captured carry
rsp_zero  output  1  1 when rsp_data == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst=1 or after reset: state IDLE, all register-file entries 0, alu_a/alu_b/alu_sel 0, rsp_valid/rsp_data/rsp_carry/rsp_zero 0. cmd_ready is 1 in the first cycle after rst deasserts.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: cmd_ready=1. On cmd_valid & cmd_ready, register:
    - alu_a <= reg[cmd_src_a]
    - alu_b <= cmd_imm_en ? cmd_imm : reg[cmd_src_b]
    - alu_sel <= cmd_op
    - latch cmd_dst and cmd_wb
    - go to EXEC
  - EXEC: exactly one cycle; cmd_ready=0. ALU inputs are stable for the whole cycle. At the end of the cycle:
    - rsp_data <= alu_result, rsp_carry <= alu_carry, rsp_zero <= (alu_result==0), rsp_valid <= 1
    - if cmd_wb, reg[dst] <= alu_result
    - go to RESP
  - RESP: cmd_ready=0. rsp_* stay constant until rsp_valid & rsp_ready. On that handshake rsp_valid <= 0 and the FSM goes to IDLE.
- Timing: accept at edge N; ALU inputs valid N+1; rsp_valid=1 from N+2. Minimum issue interval is 3 cycles. A command with cmd_valid high while not in IDLE is not accepted.
- alu_a, alu_b and alu_sel hold their last values outside EXEC; no glitch-free requirement.
- Carry is passed through without reinterpretation. For op 001 the ALU reports borrow as carry=1 when A<B unsigned. For ops 010-111 carry is 0.
- All arithmetic wraps modulo 2**WIDTH (done by the ALU). The block adds no arithmetic of its own.
- Register reads are sampled before same-edge writes:
  - an ld to the source register on the accept edge is not seen by that command;
  - the next command sees it.
- ld_en is accepted in any state. If ld and EXEC writeback target the same address on the same edge, the writeback wins and the ld is dropped. Different addresses both write.
- A dependent back-to-back command reads the written-back value, guaranteed by the 3-cycle interval.
- Reset mid-operation aborts immediately: no writeback, no response.

Test Plan:
- Reset; ld r0=0xFFFF, r1=0x0001; cmd op=000 dst=2 a=0 b=1 wb=1 -> at accept+1 alu_a=FFFF, alu_b=0001, alu_sel=000; at accept+2 rsp_data=0000, carry=1, zero=1; r2=0000.
- ld r0=0x0003, r1=0x0005; op=001 -> rsp_data=0xFFFE, carry=1, zero=0.
- ld r0=0x00FF; op=111, imm_en=1, imm=0x0F0F, wb=0 -> rsp_data=0x0FF0, carry=0; r-file unchanged.
- Hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp_* stable and cmd_ready=0 throughout. After the handshake, cmd_ready=1 the next cycle and the pending command is accepted.
- cmd1 r2=r0+r1 (0x1234+0x0001), then cmd2 op=101 a=2 -> cmd2 sees 0x1235 and returns 0x1236. ld r2=0xAAAA on cmd1's EXEC edge -> r2=0x1235 (writeback wins).
- Assert rst during EXEC -> outputs 0 immediately, rsp_valid never rises, all registers 0, cmd_ready=1 after release.
